// File: rtl/aclk_pkg.sv
// aclk_pkg: digit type, digit limits and reset time shared by the alarm-clock time keeper
package aclk_pkg;
    typedef logic [3:0] digit_t;
    typedef struct packed {
        digit_t ms_hr;
        digit_t ls_hr;
        digit_t ms_min;
        digit_t ls_min;
    } time_t;
    localparam digit_t MAX_LS_MIN = 4'd9;
    localparam digit_t MAX_MS_MIN = 4'd5;
    localparam digit_t MAX_LS_HR = 4'd9;
    localparam digit_t MAX_MS_HR = 4'd2;
    localparam digit_t MAX_LS_HR_AT_20 = 4'd3;
    localparam time_t RESET_TIME = '0;
endpackage

// File: rtl/aclk_bcd_digit.sv
// aclk_bcd_digit: loadable BCD digit that wraps to 0 and carries once it reaches or exceeds its limit
module aclk_bcd_digit
    import aclk_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   load,
    input  digit_t load_val,
    input  digit_t limit,
    output digit_t q,
    output logic   carry
);
    assign carry = en && q >= limit;
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (load) q <= load_val;
        else if (en) q <= carry ? '0 : q + 4'd1;
endmodule

// File: rtl/aclk_counter.sv
// aclk_counter: 24-hour BCD HH:MM keeper; ACLK_COUNTER_LOAD_CHECK_EN rejects loads of invalid times
module aclk_counter
    import aclk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min
);
    logic   load_ok, inc, ls_carry, hr_tick, hr_bad, hr_wrap;
    digit_t ms_hr, ls_hr;
`ifdef ACLK_COUNTER_LOAD_CHECK_EN
    logic load_valid;
    assign load_valid = new_current_time_ms_hr <= MAX_MS_HR && new_current_time_ls_hr <= MAX_LS_HR &&
                        !(new_current_time_ms_hr == MAX_MS_HR && new_current_time_ls_hr > MAX_LS_HR_AT_20) &&
                        new_current_time_ms_min <= MAX_MS_MIN && new_current_time_ls_min <= MAX_LS_MIN;
    assign load_ok = load_new_c && load_valid;
`else
    assign load_ok = load_new_c;
`endif
    assign inc = one_minute && !load_ok;
    aclk_bcd_digit u_ls_min (
        .clk(clk), .reset(reset), .en(inc), .load(load_ok), .load_val(new_current_time_ls_min),
        .limit(MAX_LS_MIN), .q(current_time_ls_min), .carry(ls_carry)
    );
    aclk_bcd_digit u_ms_min (
        .clk(clk), .reset(reset), .en(ls_carry), .load(load_ok), .load_val(new_current_time_ms_min),
        .limit(MAX_MS_MIN), .q(current_time_ms_min), .carry(hr_tick)
    );
    // an hour value above 23 can only come from an unchecked load; any tick normalises it to 00
    assign hr_bad = ms_hr > MAX_MS_HR || ls_hr > MAX_LS_HR || (ms_hr == MAX_MS_HR && ls_hr > MAX_LS_HR_AT_20);
    assign hr_wrap = hr_bad || (hr_tick && ms_hr >= MAX_MS_HR && ls_hr >= MAX_LS_HR_AT_20);
    always_ff @(posedge clk or posedge reset)
        if (reset) {ms_hr, ls_hr} <= {RESET_TIME.ms_hr, RESET_TIME.ls_hr};
        else if (load_ok) {ms_hr, ls_hr} <= {new_current_time_ms_hr, new_current_time_ls_hr};
        else if (inc && hr_wrap) {ms_hr, ls_hr} <= '0;
        else if (hr_tick) {ms_hr, ls_hr} <= ls_hr >= MAX_LS_HR ? {ms_hr + 4'd1, 4'd0} : {ms_hr, ls_hr + 4'd1};
    assign current_time_ms_hr = ms_hr;
    assign current_time_ls_hr = ls_hr;
endmodule

// File: tb/tb_aclk_counter.sv
// tb_aclk_counter: directed and random checks of aclk_counter against a minutes-of-day model
module tb_aclk_counter;
    logic clk = 0, reset = 1, one_minute = 0, load_new_c = 0;
    logic [3:0] n_ms_hr = 0, n_ls_hr = 0, n_ms_min = 0, n_ls_min = 0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    int errors = 0, checks = 0;
    int mh = 0, mm = 0;

    aclk_counter dut (
        .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
        .new_current_time_ms_hr(n_ms_hr), .new_current_time_ls_hr(n_ls_hr),
        .new_current_time_ms_min(n_ms_min), .new_current_time_ls_min(n_ls_min),
        .current_time_ms_hr(ms_hr), .current_time_ls_hr(ls_hr),
        .current_time_ms_min(ms_min), .current_time_ls_min(ls_min)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expected();
        return {4'(mh / 10), 4'(mh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    task automatic check(input string tag);
        logic [15:0] obs, exp;
        obs = {ms_hr, ls_hr, ms_min, ls_min};
        exp = expected();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        if (mh > 23) begin
            mh = 0;
            mm = (mm + 1) % 60;
        end else begin
            int t;
            t = (mh * 60 + mm + 1) % 1440;
            mh = t / 60;
            mm = t % 60;
        end
    endtask

    // one clock: drive on the falling edge, update the model, sample 1 ns after the rising edge
    task automatic step(input bit ld, input bit tk, input int h, input int m, input string tag);
        bit ok;
        @(negedge clk);
        load_new_c = ld;
        one_minute = tk;
        n_ms_hr = 4'(h / 10);
        n_ls_hr = 4'(h % 10);
        n_ms_min = 4'(m / 10);
        n_ls_min = 4'(m % 10);
`ifdef ACLK_COUNTER_LOAD_CHECK_EN
        ok = h <= 23 && m <= 59;
`else
        ok = 1;
`endif
        @(posedge clk);
        if (ld && ok) begin
            mh = h;
            mm = m;
        end else if (tk) advance();
        #1;
        load_new_c = 0;
        one_minute = 0;
        check(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset_state");
        @(negedge clk) reset = 0;
        step(1, 0, 12, 34, "load_after_release");
        step(0, 1, 0, 0, "tick_12_35");
        @(negedge clk);
        #2 reset = 1;
        mh = 0;
        mm = 0;
        #1 check("reset_async");
        @(posedge clk);
        #1 check("reset_hold");
        @(negedge clk) reset = 0;
        step(1, 0, 9, 59, "load_09_59");
        step(0, 1, 0, 0, "tick_10_00");
        step(1, 0, 19, 59, "load_19_59");
        step(0, 1, 0, 0, "tick_20_00");
        step(1, 0, 23, 59, "load_23_59");
        step(0, 1, 0, 0, "tick_00_00");
        step(1, 1, 5, 0, "load_beats_tick");
        step(0, 0, 0, 0, "hold");
        step(1, 0, 0, 58, "load_00_58");
        step(0, 1, 0, 0, "level_1");
        step(0, 1, 0, 0, "level_2");
        step(0, 1, 0, 0, "level_3");
        step(1, 0, 12, 34, "load_12_34");
        step(1, 0, 24, 0, "load_24_00");
        step(0, 1, 0, 0, "tick_after_24");
        step(1, 0, 12, 34, "reload_12_34");
        step(1, 1, 24, 0, "bad_load_with_tick");
        step(1, 0, 23, 59, "load_23_59_again");
        step(0, 1, 0, 0, "wrap_again");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 23), $urandom_range(0, 59), "random");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
